// File: rtl/find_unit_clause.sv
// find_unit_clause: flags a 3-literal CNF clause as unit when it is active and
// exactly one literal is still open. It reports that literal and its index.
// It also flags an active clause with no open literal as a conflict.
// All outputs are registered, with one clause evaluated per clock.
module find_unit_clause #(
   parameter int WIDTH = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3*WIDTH-1:0] CNF_clause_packed,
   input  logic               clause_active,
   input  logic [2:0]         clause_in,
   output logic [WIDTH-1:0]   unit_clause,
   output logic               unit_clause_detected,
   output logic [1:0]         unit_clause_idx,
   output logic               clause_conflict
);

   localparam int NUM_LIT = 3;

   logic [NUM_LIT-1:0][WIDTH-1:0] lit;
   logic [NUM_LIT-1:0]            lit_nz;

   logic [WIDTH-1:0] unit_clause_d,          unit_clause_q;
   logic             unit_clause_detected_d, unit_clause_detected_q;
   logic [1:0]       unit_clause_idx_d,      unit_clause_idx_q;
   logic             clause_conflict_d,      clause_conflict_q;

   // L0 occupies the low bits, so the packed-array view lines up with the bus directly.
   assign lit = CNF_clause_packed;

   // A zero literal names no variable, so it can never be a propagation candidate.
   for (genvar i = 0; i < NUM_LIT; i++) begin : g_nz
      assign lit_nz[i] = |lit[i];
   end

   // Decode the single open literal. Multi-hot or empty open masks never count as unit.
   always_comb begin
      unit_clause_d          = '0;
      unit_clause_idx_d      = 2'd0;
      unit_clause_detected_d = 1'b0;
      clause_conflict_d      = clause_active & (clause_in == 3'b000);
      if (clause_active) begin
         unique case (clause_in)
            3'b001: if (lit_nz[0]) begin
               unit_clause_d          = lit[0];
               unit_clause_idx_d      = 2'd0;
               unit_clause_detected_d = 1'b1;
            end
            3'b010: if (lit_nz[1]) begin
               unit_clause_d          = lit[1];
               unit_clause_idx_d      = 2'd1;
               unit_clause_detected_d = 1'b1;
            end
            3'b100: if (lit_nz[2]) begin
               unit_clause_d          = lit[2];
               unit_clause_idx_d      = 2'd2;
               unit_clause_detected_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Output registers. Reset clears every result immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unit_clause_q          <= '0;
         unit_clause_idx_q      <= 2'd0;
         unit_clause_detected_q <= 1'b0;
         clause_conflict_q      <= 1'b0;
      end else begin
         unit_clause_q          <= unit_clause_d;
         unit_clause_idx_q      <= unit_clause_idx_d;
         unit_clause_detected_q <= unit_clause_detected_d;
         clause_conflict_q      <= clause_conflict_d;
      end
   end

   assign unit_clause          = unit_clause_q;
   assign unit_clause_detected = unit_clause_detected_q;
   assign unit_clause_idx      = unit_clause_idx_q;
   assign clause_conflict      = clause_conflict_q;

endmodule

// File: tb/tb_find_unit_clause.sv
// Bench for find_unit_clause: directed clauses plus random clauses.
// Each result is checked against a rule-level reference model one edge after the inputs are applied.
module tb_find_unit_clause;

   localparam int W = 9;

   logic           clk = 1'b0;
   logic           rst;
   logic [3*W-1:0] CNF_clause_packed;
   logic           clause_active;
   logic [2:0]     clause_in;
   logic [W-1:0]   unit_clause;
   logic           unit_clause_detected;
   logic [1:0]     unit_clause_idx;
   logic           clause_conflict;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] e_lit;
   logic         e_det;
   logic [1:0]   e_idx;
   logic         e_conf;

   find_unit_clause #(.WIDTH(W)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .CNF_clause_packed   (CNF_clause_packed),
      .clause_active       (clause_active),
      .clause_in           (clause_in),
      .unit_clause         (unit_clause),
      .unit_clause_detected(unit_clause_detected),
      .unit_clause_idx     (unit_clause_idx),
      .clause_conflict     (clause_conflict)
   );

   always #5 clk = ~clk;

   // Build the packed clause {L2,L1,L0} from signed integers.
   function automatic logic [3*W-1:0] pack(input int l2, input int l1, input int l0);
      logic [W-1:0] a, b, c;
      a = W'(l2);
      b = W'(l1);
      c = W'(l0);
      return {a, b, c};
   endfunction

   // Reference model. Count the open literals. Exactly one open, non-zero literal on an
   // active clause is unit. An active clause with no open literal is a conflict.
   task automatic model(input logic [3*W-1:0] cl, input logic act, input logic [2:0] open);
      int n_open, k;
      logic [W-1:0] l [3];
      for (int i = 0; i < 3; i++) l[i] = cl[i*W +: W];
      n_open = 0;
      k = 0;
      for (int i = 0; i < 3; i++) if (open[i]) begin n_open++; k = i; end
      e_lit = '0; e_det = 1'b0; e_idx = 2'd0;
      e_conf = act && (n_open == 0);
      if (act && n_open == 1 && l[k] != 0) begin
         e_lit = l[k]; e_det = 1'b1; e_idx = 2'(k);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".det"},  32'(unit_clause_detected), 32'(e_det));
      check({tag, ".lit"},  32'(unit_clause),          32'(e_lit));
      check({tag, ".idx"},  32'(unit_clause_idx),      32'(e_idx));
      check({tag, ".conf"}, 32'(clause_conflict),      32'(e_conf));
   endtask

   // Apply one clause on the falling edge, then check the result just after the next rising edge.
   task automatic step(input string tag, input logic [3*W-1:0] cl, input logic act,
                       input logic [2:0] open);
      @(negedge clk);
      CNF_clause_packed = cl;
      clause_active     = act;
      clause_in         = open;
      model(cl, act, open);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b1;
      CNF_clause_packed = pack(-1, 6, 7);
      clause_active = 1'b1;
      clause_in = 3'b001;
      repeat (2) @(posedge clk);
      #1;
      e_lit = '0; e_det = 1'b0; e_idx = 2'd0; e_conf = 1'b0;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Directed clauses.
      step("c1", pack(-1, 6, 7), 1'b1, 3'b001);
      check("c1.const", 32'(unit_clause), 32'(9'd7));
      step("c2", pack(-8, -2, -3), 1'b1, 3'b100);
      check("c2.const", 32'(unit_clause), 32'(9'h1F8));
      check("c2.idx_const", 32'(unit_clause_idx), 32'd2);
      step("c3", pack(-1, 46, 71), 1'b1, 3'b010);
      check("c3.const", 32'(unit_clause), 32'(9'd46));
      step("c4a", pack(1, 2, 25), 1'b1, 3'b101);
      step("c4b", pack(-5, -6, 8), 1'b1, 3'b111);
      step("c4c", pack(8, 5, 67), 1'b0, 3'b001);
      check("c4c.const", 32'(unit_clause_detected), 32'd0);
      step("c5a", pack(6, 4, 3), 1'b1, 3'b000);
      check("c5a.const", 32'(clause_conflict), 32'd1);
      step("c5b", pack(6, 4, 3), 1'b0, 3'b000);
      step("zero_lit", pack(5, 0, 3), 1'b1, 3'b010);
      step("max_neg", pack(-256, 0, 0), 1'b1, 3'b100);

      // Asynchronous reset between edges.
      step("pre_rst", pack(-1, 6, 7), 1'b1, 3'b001);
      #2;
      rst = 1'b1;
      #1;
      e_lit = '0; e_det = 1'b0; e_idx = 2'd0; e_conf = 1'b0;
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      model(CNF_clause_packed, clause_active, clause_in);
      @(posedge clk);
      #1;
      check_all("post_rst");

      // Random clauses. Zero literals are biased so the invalid-literal case occurs often.
      for (int n = 0; n < 300; n++) begin
         int l0, l1, l2;
         l0 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
         l1 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
         l2 = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom);
         step("rand", pack(l2, l1, l0), 1'($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)));
         checks++;
         assert (!(unit_clause_detected && clause_conflict)) else begin
            failures++;
            $error("FAIL rand.excl observed=%0b%0b expected=not both",
                   unit_clause_detected, clause_conflict);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
